// File: rtl/cpu_bus_sequencer.sv
// CPU external-bus sequencer: synchronizes NCS/NWE/NRD, decodes accesses into control
// registers, waveform-RAM loads and read-back. Optional stuck-access watchdog: CPU_BUS_TIMEOUT_EN.
module cpu_bus_sequencer #(
   parameter int RAM_AW  = 12,
   parameter int TIMEOUT = 255
) (
   input  logic              FPGA_Clock,
   input  logic              FPGA_Reset,
   input  logic              CPU_NCS,
   input  logic              CPU_NWE,
   input  logic              CPU_NRD,
   input  logic [25:0]       CPU_Addr,
   input  logic [15:0]       CPU_Data,
   output logic [15:0]       RD_Data,
   output logic              INOUT_CTRL,
   output logic              Ram_WE,
   output logic [RAM_AW-1:0] Ram_Addr,
   output logic [15:0]       Ram_WData,
   output logic              Run,
   output logic [31:0]       Phase_Inc,
   output logic [15:0]       Amplitude,
   input  logic              Play_Busy
);

   // state      | meaning
   // IDLE       | waiting for a strobe with chip select
   // WR_ARM     | capture address and data
   // WR_HOLD    | wait for NWE or NCS to rise
   // WR_COMMIT  | perform the captured write
   // RD_DRIVE   | FPGA drives the data bus with RD_Data
   // RELEASE    | bus released, wait for all strobes high
   typedef enum logic [2:0] {
      S_IDLE, S_WR_ARM, S_WR_HOLD, S_WR_COMMIT, S_RD_DRIVE, S_RELEASE
   } state_t;

   state_t state, state_nxt;

   logic [1:0]        ncs_sync, nwe_sync, nrd_sync;
   logic              ncs_s, nwe_s, nrd_s, all_high;
   logic              cap_ram;
   logic [2:0]        cap_idx;
   logic [RAM_AW-1:0] cap_ram_addr;
   logic [15:0]       cap_data;
   logic              run_q;
   logic [15:0]       shadow_q, ampl_q, rd_data_q, rd_val;
   logic [31:0]       pinc_q;
   logic              wr_reject, timeout_err;
   logic              tmo_hit, tmo_lock;
   logic              ram_we_c, commit;
   logic              unused_addr;

   assign unused_addr = ^CPU_Addr[24:0];

   always_ff @(posedge FPGA_Clock or negedge FPGA_Reset) begin
      if (!FPGA_Reset) begin
         ncs_sync <= 2'b11;
         nwe_sync <= 2'b11;
         nrd_sync <= 2'b11;
      end else begin
         ncs_sync <= {ncs_sync[0], CPU_NCS};
         nwe_sync <= {nwe_sync[0], CPU_NWE};
         nrd_sync <= {nrd_sync[0], CPU_NRD};
      end
   end

   assign ncs_s    = ncs_sync[1];
   assign nwe_s    = nwe_sync[1];
   assign nrd_s    = nrd_sync[1];
   assign all_high = ncs_s & nwe_s & nrd_s;

`ifdef CPU_BUS_TIMEOUT_EN
   localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   logic [TW-1:0] tmo_cnt;
   logic          counting;

   assign counting = (state == S_WR_HOLD) || (state == S_RD_DRIVE) || (state == S_RELEASE);
   assign tmo_hit  = counting && (tmo_cnt == '0);

   // Down-counter reloads in IDLE and runs across the whole stretched part of an access.
   always_ff @(posedge FPGA_Clock or negedge FPGA_Reset) begin
      if (!FPGA_Reset) begin
         tmo_cnt  <= '0;
         tmo_lock <= 1'b0;
      end else begin
         if (state == S_IDLE)
            tmo_cnt <= TW'(TIMEOUT);
         else if (counting && tmo_cnt != '0)
            tmo_cnt <= tmo_cnt - TW'(1);

         if (tmo_hit)
            tmo_lock <= 1'b1;
         else if (all_high)
            tmo_lock <= 1'b0;
      end
   end
`else
   logic unused_tmo_cfg;

   assign unused_tmo_cfg = (TIMEOUT == 0);
   assign tmo_hit        = 1'b0;
   assign tmo_lock       = 1'b0;
`endif

   always_ff @(posedge FPGA_Clock or negedge FPGA_Reset) begin
      if (!FPGA_Reset)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (!tmo_lock && !ncs_s && !nwe_s)
               state_nxt = S_WR_ARM;
            else if (!tmo_lock && !ncs_s && !nrd_s)
               state_nxt = S_RD_DRIVE;
         end
         S_WR_ARM:    state_nxt = S_WR_HOLD;
         S_WR_HOLD:   if (nwe_s || ncs_s) state_nxt = S_WR_COMMIT;
         S_WR_COMMIT: state_nxt = S_RELEASE;
         S_RD_DRIVE:  if (nrd_s || ncs_s) state_nxt = S_RELEASE;
         S_RELEASE:   if (all_high) state_nxt = S_IDLE;
         default:     state_nxt = S_IDLE;
      endcase
      if (tmo_hit)
         state_nxt = S_IDLE;
   end

   always_comb begin
      INOUT_CTRL = (state != S_RD_DRIVE);
      commit     = (state == S_WR_COMMIT);
      ram_we_c   = commit && cap_ram && !run_q && !Play_Busy;
   end

   always_comb begin
      rd_val = '0;
      if (!CPU_Addr[25]) begin
         case (CPU_Addr[2:0])
            3'd0:    rd_val = {15'b0, run_q};
            3'd1:    rd_val = shadow_q;
            3'd2:    rd_val = pinc_q[31:16];
            3'd3:    rd_val = ampl_q;
            3'd4:    rd_val = {13'b0, timeout_err, Play_Busy, wr_reject};
            default: rd_val = '0;
         endcase
      end
   end

   always_ff @(posedge FPGA_Clock or negedge FPGA_Reset) begin
      if (!FPGA_Reset) begin
         cap_ram      <= 1'b0;
         cap_idx      <= '0;
         cap_ram_addr <= '0;
         cap_data     <= '0;
         rd_data_q    <= '0;
      end else begin
         if (state == S_WR_ARM) begin
            cap_ram      <= CPU_Addr[25];
            cap_idx      <= CPU_Addr[2:0];
            cap_ram_addr <= CPU_Addr[RAM_AW-1:0];
            cap_data     <= CPU_Data;
         end
         if (state == S_IDLE && state_nxt == S_RD_DRIVE)
            rd_data_q <= rd_val;
      end
   end

   // PINC_HI merges the captured high half with the shadowed low half in one edge.
   always_ff @(posedge FPGA_Clock or negedge FPGA_Reset) begin
      if (!FPGA_Reset) begin
         run_q       <= 1'b0;
         shadow_q    <= '0;
         pinc_q      <= '0;
         ampl_q      <= '0;
         wr_reject   <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         if (commit && !cap_ram) begin
            case (cap_idx)
               3'd0: run_q    <= cap_data[0];
               3'd1: shadow_q <= cap_data;
               3'd2: pinc_q   <= {cap_data, shadow_q};
               3'd3: ampl_q   <= cap_data;
               3'd4: begin
                  wr_reject   <= 1'b0;
                  timeout_err <= 1'b0;
               end
               default: ;
            endcase
         end
         if (commit && cap_ram && (run_q || Play_Busy))
            wr_reject <= 1'b1;
         if (tmo_hit)
            timeout_err <= 1'b1;
      end
   end

   assign RD_Data   = rd_data_q;
   assign Ram_WE    = ram_we_c;
   assign Ram_Addr  = cap_ram_addr;
   assign Ram_WData = cap_data;
   assign Run       = run_q;
   assign Phase_Inc = pinc_q;
   assign Amplitude = ampl_q;

endmodule

// File: tb/tb_cpu_bus_sequencer.sv
// Scoreboard bench for cpu_bus_sequencer: random CPU accesses against a register-level model.
module tb_cpu_bus_sequencer;

   localparam int RAM_AW = 12;
`ifdef CPU_BUS_TIMEOUT_EN
   localparam int TMO = 16;
`else
   localparam int TMO = 255;
`endif

   logic              FPGA_Clock = 1'b0;
   logic              FPGA_Reset = 1'b0;
   logic              CPU_NCS = 1'b1, CPU_NWE = 1'b1, CPU_NRD = 1'b1;
   logic [25:0]       CPU_Addr = '0;
   logic [15:0]       CPU_Data = '0;
   logic [15:0]       RD_Data;
   logic              INOUT_CTRL, Ram_WE, Run, Play_Busy = 1'b0;
   logic [RAM_AW-1:0] Ram_Addr;
   logic [15:0]       Ram_WData, Amplitude;
   logic [31:0]       Phase_Inc;

   cpu_bus_sequencer #(.RAM_AW(RAM_AW), .TIMEOUT(TMO)) dut (
      .FPGA_Clock(FPGA_Clock), .FPGA_Reset(FPGA_Reset),
      .CPU_NCS(CPU_NCS), .CPU_NWE(CPU_NWE), .CPU_NRD(CPU_NRD),
      .CPU_Addr(CPU_Addr), .CPU_Data(CPU_Data),
      .RD_Data(RD_Data), .INOUT_CTRL(INOUT_CTRL),
      .Ram_WE(Ram_WE), .Ram_Addr(Ram_Addr), .Ram_WData(Ram_WData),
      .Run(Run), .Phase_Inc(Phase_Inc), .Amplitude(Amplitude),
      .Play_Busy(Play_Busy)
   );

   always #5 FPGA_Clock = ~FPGA_Clock;

   int checks = 0, failures = 0, cyc = 0, nwe_rise_cyc = 0;
   always @(posedge FPGA_Clock) cyc++;

   // reference model state
   logic        m_run = 0, m_rej = 0, m_tmo = 0;
   logic [15:0] m_shadow = 0, m_ampl = 0;
   logic [31:0] m_pinc = 0;

   logic [27:0] exp_ram_q[$];
   logic [15:0] exp_rd_q[$];
   logic [31:0] exp_pinc_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic note_fail(input string name);
      checks++;
      failures++;
      $display("FAIL %s actual=event required=none", name);
   endtask

   function automatic logic [15:0] model_read(input logic [25:0] a);
      if (a[25]) return 16'h0000;
      case (a[2:0])
         3'd0: return {15'b0, m_run};
         3'd1: return m_shadow;
         3'd2: return m_pinc[31:16];
         3'd3: return m_ampl;
         3'd4: return {13'b0, m_tmo, Play_Busy, m_rej};
         default: return 16'h0000;
      endcase
   endfunction

   // monitor: pops expectations whenever the DUT shows a RAM pulse, a bus turnaround or a new Phase_Inc
   logic        last_ioc = 1'b1;
   logic [31:0] last_pinc = '0;
   logic [27:0] e_ram;
   int          lat;
   always @(negedge FPGA_Clock) begin
      if (!FPGA_Reset) begin
         last_ioc  = INOUT_CTRL;
         last_pinc = Phase_Inc;
      end else begin
         if (Ram_WE) begin
            if (exp_ram_q.size() == 0) note_fail("ram_we_unexpected");
            else begin
               e_ram = exp_ram_q.pop_front();
               check("ram_addr", 32'(Ram_Addr), 32'(e_ram[27:16]));
               check("ram_wdata", 32'(Ram_WData), 32'(e_ram[15:0]));
               lat = cyc - nwe_rise_cyc;
               checks++;
               if (lat < 3 || lat > 5) begin
                  failures++;
                  $display("FAIL ram_latency actual=%0d required=3..5", lat);
               end
            end
         end
         if (last_ioc && !INOUT_CTRL) begin
            if (exp_rd_q.size() == 0) note_fail("read_unexpected");
            else check("rd_data", 32'(RD_Data), 32'(exp_rd_q.pop_front()));
         end
         if (Phase_Inc !== last_pinc) begin
            if (exp_pinc_q.size() == 0) note_fail("phase_inc_unexpected");
            else check("phase_inc_step", Phase_Inc, exp_pinc_q.pop_front());
         end
         last_ioc  = INOUT_CTRL;
         last_pinc = Phase_Inc;
      end
   end

   task automatic model_write(input logic [25:0] a, input logic [15:0] d);
      if (a[25]) begin
         if (!m_run && !Play_Busy) exp_ram_q.push_back({a[11:0], d});
         else m_rej = 1'b1;
      end else begin
         case (a[2:0])
            3'd0: m_run = d[0];
            3'd1: m_shadow = d;
            3'd2: begin
               if ({d, m_shadow} != m_pinc) exp_pinc_q.push_back({d, m_shadow});
               m_pinc = {d, m_shadow};
            end
            3'd3: m_ampl = d;
            3'd4: begin m_rej = 1'b0; m_tmo = 1'b0; end
            default: ;
         endcase
      end
   endtask

   task automatic bus_write(input logic [25:0] a, input logic [15:0] d);
      model_write(a, d);
      @(posedge FPGA_Clock); #2;
      CPU_Addr = a; CPU_Data = d; CPU_NCS = 0; CPU_NWE = 0;
      repeat (6) @(posedge FPGA_Clock);
      #2;
      CPU_NWE = 1; CPU_NCS = 1; nwe_rise_cyc = cyc;
      repeat (8) @(posedge FPGA_Clock);
      #2;
      check("run", 32'(Run), 32'(m_run));
      check("amplitude", 32'(Amplitude), 32'(m_ampl));
      check("phase_inc", Phase_Inc, m_pinc);
   endtask

   task automatic bus_read(input logic [25:0] a);
      @(posedge FPGA_Clock); #2;
      exp_rd_q.push_back(model_read(a));
      CPU_Addr = a; CPU_NCS = 0; CPU_NRD = 0;
      repeat (6) @(posedge FPGA_Clock);
      #2;
      check("ioc_during_read", 32'(INOUT_CTRL), 32'(0));
      CPU_NRD = 1; CPU_NCS = 1;
      repeat (8) @(posedge FPGA_Clock);
      #2;
      check("ioc_after_read", 32'(INOUT_CTRL), 32'(1));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [25:0] ra;
      logic [15:0] rd;
      int          ret_cyc, start_cyc;

      repeat (3) @(posedge FPGA_Clock);
      #1;
      check("rst_inout_ctrl", 32'(INOUT_CTRL), 32'(1));
      check("rst_rd_data", 32'(RD_Data), 32'(0));
      check("rst_ram_we", 32'(Ram_WE), 32'(0));
      check("rst_ram_addr", 32'(Ram_Addr), 32'(0));
      check("rst_ram_wdata", 32'(Ram_WData), 32'(0));
      check("rst_run", 32'(Run), 32'(0));
      check("rst_phase_inc", Phase_Inc, 32'(0));
      check("rst_amplitude", 32'(Amplitude), 32'(0));
      #1 FPGA_Reset = 1'b1;
      repeat (3) @(posedge FPGA_Clock);

      bus_write(26'h0000001, 16'h1234);
      bus_write(26'h0000002, 16'hABCD);
      check("pinc_atomic", Phase_Inc, 32'hABCD1234);

      bus_write(26'h2000005, 16'h7FFF);

      bus_write(26'h0000000, 16'h0001);
      Play_Busy = 1'b1;
      bus_write(26'h2000010, 16'h5A5A);
      bus_read(26'h0000004);
      Play_Busy = 1'b0;
      bus_write(26'h0000004, 16'h0000);
      bus_read(26'h0000004);
      bus_write(26'h0000000, 16'h0000);

      bus_write(26'h0000003, 16'h0400);
      bus_read(26'h0000003);
      bus_read(26'h2000003);
      bus_read(26'h0000006);

      for (int i = 0; i < 40; i++) begin
         Play_Busy = ($urandom_range(0, 3) == 0);
         rd = 16'($urandom_range(0, 65535));
         case ($urandom_range(0, 3))
            0: begin ra = {1'b0, 22'($urandom), 3'($urandom_range(0, 7))}; bus_write(ra, rd); end
            1: begin ra = {1'b0, 22'($urandom), 3'($urandom_range(0, 7))}; bus_read(ra); end
            2: begin ra = {1'b1, 25'($urandom)}; bus_write(ra, rd); end
            default: begin ra = {1'b1, 25'($urandom)}; bus_read(ra); end
         endcase
      end
      Play_Busy = 1'b0;
      bus_write(26'h0000000, 16'h0000);

      // reset in the middle of a PINC_HI write, strobes held through reset release
      bus_write(26'h0000001, 16'h5555);
      @(posedge FPGA_Clock); #2;
      CPU_Addr = 26'h0000002; CPU_Data = 16'hABCD; CPU_NCS = 0; CPU_NWE = 0;
      repeat (5) @(posedge FPGA_Clock);
      #2;
      FPGA_Reset = 1'b0;
      #1;
      check("rst_mid_inout_ctrl", 32'(INOUT_CTRL), 32'(1));
      check("rst_mid_phase_inc", Phase_Inc, 32'(0));
      m_run = 0; m_rej = 0; m_tmo = 0; m_shadow = 0; m_ampl = 0; m_pinc = 0;
      exp_ram_q.delete(); exp_rd_q.delete(); exp_pinc_q.delete();
      repeat (3) @(posedge FPGA_Clock);
      #2;
      FPGA_Reset = 1'b1;
      repeat (8) @(posedge FPGA_Clock);
      #2;
      check("no_commit_while_held", Phase_Inc, 32'(0));
      exp_pinc_q.push_back(32'hABCD0000);
      m_pinc = 32'hABCD0000;
      CPU_NWE = 1; CPU_NCS = 1; nwe_rise_cyc = cyc;
      repeat (8) @(posedge FPGA_Clock);
      #2;
      check("commit_after_release", Phase_Inc, 32'hABCD0000);

`ifdef CPU_BUS_TIMEOUT_EN
      bus_write(26'h0000004, 16'h0000);
      @(posedge FPGA_Clock); #2;
      exp_rd_q.push_back(model_read(26'h0000004));
      CPU_Addr = 26'h0000004; CPU_NCS = 0; CPU_NRD = 0;
      start_cyc = cyc;
      ret_cyc = -1;
      for (int k = 0; k < 40; k++) begin
         @(posedge FPGA_Clock); #2;
         if (ret_cyc < 0 && k > 4 && INOUT_CTRL) ret_cyc = cyc - start_cyc;
      end
      checks++;
      if (ret_cyc < 16 || ret_cyc > 22) begin
         failures++;
         $display("FAIL timeout_release actual=%0d required=16..22", ret_cyc);
      end
      check("timeout_lock_ioc", 32'(INOUT_CTRL), 32'(1));
      CPU_NRD = 1; CPU_NCS = 1;
      m_tmo = 1'b1;
      repeat (8) @(posedge FPGA_Clock);
      bus_read(26'h0000004);
`else
      start_cyc = 0;
      ret_cyc = 0;
      bus_read(26'h0000004);
`endif

      repeat (10) @(posedge FPGA_Clock);
      check("ram_q_drained", 32'(exp_ram_q.size()), 32'(0));
      check("rd_q_drained", 32'(exp_rd_q.size()), 32'(0));
      check("pinc_q_drained", 32'(exp_pinc_q.size()), 32'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
